stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
- Return-address stack controller that sits directly upstream of the data memory's PC/SP port.
- Sequences CALL pushes and RET pops from the control unit into the stack region of data memory.
- Drives sp_address, pc_data and signal_pc_data_write, and consumes the registered pc_read_data.
- Owns the stack pointer, depth tracking, and overflow/underflow detection; the stack grows downward from SP_TOP.

Parameters:
- SP_TOP, 399, highest stack word address; first push lands here.
- SP_BASE, 336, lowest stack word address; DEPTH = SP_TOP - SP_BASE + 1 (default 64).
- AW, 9, address width (matches data memory address).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- push_req  input  1  push request; sampled only while busy=0.
- pop_req  input  1  pop request; sampled only while busy=0.
- push_data  input  16  return PC to push.
- mem_busy  input  1  OR of mem_write, ACC write and crypto write; these outrank PC writes in memory.
- pc_read_data  input  16  registered memory read at sp_address, valid 1 cycle after address.
- sp_address  output  AW  memory address for stack access.
- pc_data  output  16  write data to memory.
- signal_pc_data_write  output  1  memory write strobe.
- busy  output  1  operation in flight; new requests ignored.
- pop_valid  output  1  one-cycle pulse; pop_data valid.
- pop_data  output  16  popped return PC.
- depth  output  AW  current entries, 0..DEPTH.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.
- clear_err  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Internal sp = next free slot.
- Reset (async, takes effect immediately, including mid-operation):
  - state=IDLE, sp=SP_TOP, depth=0.
  - All outputs 0, sp_address=SP_TOP.
  - An in-flight write strobe drops immediately; no partial push is counted.
- All outputs are registered.
- States: IDLE, PUSH_WR, POP_RD, POP_CAP.
- IDLE (busy=0):
  - Push has priority when push_req and pop_req are both high; the pop is dropped and the requester re-issues it.
  - Push, depth<DEPTH: pc_data<=push_data, sp_address<=sp, signal_pc_data_write<=1, busy<=1, go to PUSH_WR.
  - Push, depth==DEPTH: overflow<=1; no write; sp and depth unchanged; stay in IDLE.
  - Pop, depth>0: sp_address<=sp+1, busy<=1, go to POP_RD.
  - Pop, depth==0: underflow<=1; no pop_valid; stay in IDLE.
- PUSH_WR:
  - If mem_busy=1: hold the strobe, address and data; remain in PUSH_WR.
  - Otherwise the memory commits on this edge; strobe<=0, sp<=sp-1, depth<=depth+1, busy<=0, go to IDLE.
  - Latency: request edge to busy low = 2 cycles minimum, plus 1 per mem_busy cycle.
- POP_RD:
  - Memory samples sp_address this edge; go to POP_CAP.
  - mem_busy is not checked; the read port is independent.
- POP_CAP:
  - pop_data<=pc_read_data, pop_valid<=1 for one cycle, sp<=sp+1, depth<=depth-1, busy<=0, go to IDLE.
  - Latency: request edge to pop_valid = 3 cycles.
- sp never leaves [SP_BASE-1, SP_TOP]; no wrap-around is possible because of the full/empty guards.
- Error flags:
  - Sticky until reset or clear_err.
  - If clear_err and a new error occur in the same cycle, the new error wins (flag = 1).
- Requests asserted while busy=1 are ignored and are not queued.

Optional Feature:
- Macro: STACK_HIGH_WATER_EN.
- Defined:
  - Adds output max_depth [AW-1:0]: maximum depth reached since reset; reset value 0.
  - It updates on the same edge depth increments.
  - clear_err also resets max_depth to the current depth.
- Undefined:
  - Port and register absent; all other behaviour identical.

Test Plan:
- Reset, push_req with push_data=0x0042, mem_busy=0 -> next cycle sp_address=399, pc_data=0x0042, strobe=1 for exactly 1 cycle; then depth=1, busy=0.
- After the push above, pop_req -> sp_address=399; pop_valid pulses 3 cycles after the request with pop_data=0x0042; depth=0.
- SP_BASE=396 (DEPTH=4): push 0x0001..0x0004 -> addresses 399,398,397,396. A 5th push -> overflow=1, no strobe, depth=4. Four pops return 0x0004,0x0003,0x0002,0x0001.
- Pop on an empty stack -> underflow=1, pop_valid stays 0. Then clear_err=1 for 1 cycle -> underflow=0.
- Push with mem_busy held high for 3 cycles -> strobe/address/data stable for 4 cycles; depth increments only on the cycle after mem_busy falls.
- rst asserted in PUSH_WR mid-stall -> strobe=0 immediately, depth=0, sp_address=399. A subsequent pop -> underflow=1.

Source files
------------

// File: rtl/stack_ctrl_if.sv
// rtl/stack_ctrl_if.sv - request and data-memory port bundle for the return-address stack controller
// Optional max_depth signal present only when STACK_HIGH_WATER_EN is defined.
interface stack_ctrl_if #(
    parameter int AW = 9
);
    logic          push_req;
    logic          pop_req;
    logic [15:0]   push_data;
    logic          clear_err;
    logic          busy;
    logic          pop_valid;
    logic [15:0]   pop_data;
    logic [AW-1:0] depth;
    logic          overflow;
    logic          underflow;
`ifdef STACK_HIGH_WATER_EN
    logic [AW-1:0] max_depth;
`endif
    logic          mem_busy;
    logic [15:0]   pc_read_data;
    logic [AW-1:0] sp_address;
    logic [15:0]   pc_data;
    logic          signal_pc_data_write;

    // slave: the stack controller; master: control unit plus data memory side
    modport slave (
        input  push_req, pop_req, push_data, clear_err, mem_busy, pc_read_data,
        output busy, pop_valid, pop_data, depth, overflow, underflow,
               sp_address, pc_data, signal_pc_data_write
`ifdef STACK_HIGH_WATER_EN
        , output max_depth
`endif
    );

    modport master (
        output push_req, pop_req, push_data, clear_err, mem_busy, pc_read_data,
        input  busy, pop_valid, pop_data, depth, overflow, underflow,
               sp_address, pc_data, signal_pc_data_write
`ifdef STACK_HIGH_WATER_EN
        , input max_depth
`endif
    );
endinterface

// File: rtl/stack_ctrl.sv
// rtl/stack_ctrl.sv - return-address stack controller driving the data memory PC/SP port
// Optional high-water tracking (max_depth) enabled by defining STACK_HIGH_WATER_EN.
module stack_ctrl #(
    parameter int SP_TOP  = 399,
    parameter int SP_BASE = 336,
    parameter int AW      = 9
) (
    input  logic         clk,
    input  logic         rst,
    stack_ctrl_if.slave  bus
);
    localparam logic [AW-1:0] TOP_ADDR = AW'(SP_TOP);
    localparam logic [AW-1:0] FULL     = AW'(SP_TOP - SP_BASE + 1);
    localparam logic [AW-1:0] ONE      = AW'(1);

    typedef enum logic [1:0] {
        IDLE,
        PUSH_WR,
        POP_RD,
        POP_CAP
    } state_t;

    state_t        state;
    logic [AW-1:0] sp;
    logic [AW-1:0] depth_q;
    logic [AW-1:0] addr_q;
    logic [15:0]   wdata_q;
    logic          wr_q;
    logic          busy_q;
    logic          pop_valid_q;
    logic [15:0]   pop_data_q;
    logic          overflow_q;
    logic          underflow_q;

    // sp is the next free slot; the top entry therefore lives at sp+1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sp          <= TOP_ADDR;
            depth_q     <= '0;
            addr_q      <= TOP_ADDR;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pop_valid_q <= 1'b0;
            // A clear here is overridden by any error raised below on the same edge
            if (bus.clear_err) begin
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.push_req) begin
                        if (depth_q == FULL) begin
                            overflow_q <= 1'b1;
                        end else begin
                            wdata_q <= bus.push_data;
                            addr_q  <= sp;
                            wr_q    <= 1'b1;
                            busy_q  <= 1'b1;
                            state   <= PUSH_WR;
                        end
                    end else if (bus.pop_req) begin
                        if (depth_q == '0) begin
                            underflow_q <= 1'b1;
                        end else begin
                            addr_q <= sp + ONE;
                            busy_q <= 1'b1;
                            state  <= POP_RD;
                        end
                    end
                end
                PUSH_WR: begin
                    // Higher-priority memory writers stall us with the strobe held
                    if (!bus.mem_busy) begin
                        wr_q    <= 1'b0;
                        sp      <= sp - ONE;
                        depth_q <= depth_q + ONE;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                POP_RD: begin
                    state <= POP_CAP;
                end
                POP_CAP: begin
                    pop_data_q  <= bus.pc_read_data;
                    pop_valid_q <= 1'b1;
                    sp          <= sp + ONE;
                    depth_q     <= depth_q - ONE;
                    busy_q      <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef STACK_HIGH_WATER_EN
    logic          push_commit;
    logic          pop_commit;
    logic [AW-1:0] depth_next;
    logic [AW-1:0] max_depth_q;

    always_comb begin
        push_commit = (state == PUSH_WR) && !bus.mem_busy;
        pop_commit  = (state == POP_CAP);
        depth_next  = depth_q;
        if (push_commit) begin
            depth_next = depth_q + ONE;
        end else if (pop_commit) begin
            depth_next = depth_q - ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_depth_q <= '0;
        end else if (bus.clear_err) begin
            max_depth_q <= depth_next;
        end else if (push_commit && (depth_next > max_depth_q)) begin
            max_depth_q <= depth_next;
        end
    end

    assign bus.max_depth = max_depth_q;
`endif

    assign bus.sp_address           = addr_q;
    assign bus.pc_data              = wdata_q;
    assign bus.signal_pc_data_write = wr_q;
    assign bus.busy                 = busy_q;
    assign bus.pop_valid            = pop_valid_q;
    assign bus.pop_data             = pop_data_q;
    assign bus.depth                = depth_q;
    assign bus.overflow             = overflow_q;
    assign bus.underflow            = underflow_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// tb/tb_stack_ctrl.sv - scoreboard bench for stack_ctrl against a queue-based stack model
// Checks max_depth as well when STACK_HIGH_WATER_EN is defined.
module tb_stack_ctrl;
    localparam int SP_TOP  = 399;
    localparam int SP_BASE = 396;
    localparam int DEPTH   = SP_TOP - SP_BASE + 1;

    typedef struct {
        logic [8:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stack_ctrl_if #(.AW(9)) bus ();

    stack_ctrl #(.SP_TOP(SP_TOP), .SP_BASE(SP_BASE), .AW(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    wr_t         exp_wr[$];
    logic [15:0] exp_pop[$];
    logic [15:0] stk[$];
    int          m_depth = 0;
    int          m_max   = 0;
    bit          m_ovf   = 1'b0;
    bit          m_unf   = 1'b0;

    logic [15:0] mem [0:511];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Data memory: writes yield to mem_busy; reads are registered
    always @(posedge clk) begin
        if (bus.signal_pc_data_write && !bus.mem_busy) begin
            mem[bus.sp_address] <= bus.pc_data;
        end
        bus.pc_read_data <= mem[bus.sp_address];
    end

    // Monitor: every committed write and every pop_valid must match the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.signal_pc_data_write && !bus.mem_busy) begin
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(bus.sp_address), 32'(e.addr));
                    chk("wr_data", 32'(bus.pc_data), 32'(e.data));
                end
            end
            if (bus.pop_valid) begin
                if (exp_pop.size() == 0) begin
                    chk("unexpected_pop_valid", 32'd1, 32'd0);
                end else begin
                    logic [15:0] d;
                    d = exp_pop.pop_front();
                    chk("pop_data", 32'(bus.pop_data), 32'(d));
                end
            end
        end
    end

    task automatic model_reset();
        stk.delete();
        exp_wr.delete();
        exp_pop.delete();
        m_depth = 0;
        m_max   = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_depth"}, 32'(bus.depth), 32'(m_depth));
        chk({tag, "_overflow"}, 32'(bus.overflow), 32'(m_ovf));
        chk({tag, "_underflow"}, 32'(bus.underflow), 32'(m_unf));
        chk({tag, "_strobe_idle"}, 32'(bus.signal_pc_data_write), 32'd0);
`ifdef STACK_HIGH_WATER_EN
        chk({tag, "_max_depth"}, 32'(bus.max_depth), 32'(m_max));
`endif
    endtask

    // Called at #1 after a clock edge with the controller idle
    task automatic issue(input bit p, input bit q, input logic [15:0] d, input int stall, input bit clr);
        int lat;
        int exp_lat;
        int dir;
        bit accepted;
        accepted = 1'b0;
        exp_lat  = 0;
        dir      = 0;
        bus.push_req  = p;
        bus.pop_req   = q;
        bus.push_data = d;
        bus.clear_err = clr;
        if (clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_max = m_depth;
        end
        if (p) begin
            if (m_depth == DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                exp_wr.push_back('{addr: 9'(SP_TOP - m_depth), data: d});
                stk.push_back(d);
                accepted = 1'b1;
                exp_lat  = 1 + stall;
                dir      = 1;
            end
        end else if (q) begin
            if (m_depth == 0) begin
                m_unf = 1'b1;
            end else begin
                exp_pop.push_back(stk.pop_back());
                accepted = 1'b1;
                exp_lat  = 2;
                dir      = -1;
            end
        end
        @(posedge clk); #1;
        bus.push_req  = 1'b0;
        bus.pop_req   = 1'b0;
        bus.clear_err = 1'b0;
        chk("busy_after_req", 32'(bus.busy), 32'(accepted));
        if (p) chk("strobe_after_req", 32'(bus.signal_pc_data_write), 32'(accepted));
        lat = 0;
        if (dir == 1 && stall > 0) begin
            bus.mem_busy = 1'b1;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                lat++;
                chk("stall_strobe", 32'(bus.signal_pc_data_write), 32'd1);
                chk("stall_addr", 32'(bus.sp_address), 32'(SP_TOP - m_depth));
                chk("stall_data", 32'(bus.pc_data), 32'(d));
                chk("stall_depth", 32'(bus.depth), 32'(m_depth));
            end
            bus.mem_busy = 1'b0;
        end
        // Requests raised while busy must be ignored
        while (bus.busy && lat < 20) begin
            bus.push_req  = 1'($urandom_range(0, 1));
            bus.pop_req   = 1'($urandom_range(0, 1));
            bus.push_data = 16'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        bus.push_req = 1'b0;
        bus.pop_req  = 1'b0;
        chk("latency", 32'(lat), 32'(exp_lat));
        m_depth = m_depth + dir;
        if (m_depth > m_max) m_max = m_depth;
        chk("pop_valid_at_done", 32'(bus.pop_valid), 32'(dir == -1));
        check_state("post_op");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'(i * 7 + 3);
        bus.push_req  = 1'b0;
        bus.pop_req   = 1'b0;
        bus.push_data = '0;
        bus.clear_err = 1'b0;
        bus.mem_busy  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sp_address", 32'(bus.sp_address), 32'(SP_TOP));
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_pop_valid", 32'(bus.pop_valid), 32'd0);
        chk("rst_pop_data", 32'(bus.pop_data), 32'd0);
        chk("rst_pc_data", 32'(bus.pc_data), 32'd0);
        check_state("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // Single push/pop, then fill to capacity, overflow, and drain
        issue(1'b1, 1'b0, 16'h0042, 0, 1'b0);
        issue(1'b0, 1'b1, 16'h0000, 0, 1'b0);
        for (int i = 1; i <= DEPTH + 1; i++) issue(1'b1, 1'b0, 16'(i), 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) issue(1'b0, 1'b1, 16'h0000, 0, 1'b0);
        issue(1'b0, 1'b1, 16'h0000, 0, 1'b0);
        issue(1'b0, 1'b0, 16'h0000, 0, 1'b1);
        issue(1'b1, 1'b0, 16'h1234, 3, 1'b0);

        // Reset while a push is stalled by mem_busy
        bus.push_req  = 1'b1;
        bus.push_data = 16'hbeef;
        @(posedge clk); #1;
        bus.push_req = 1'b0;
        bus.mem_busy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midstall_strobe", 32'(bus.signal_pc_data_write), 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_strobe", 32'(bus.signal_pc_data_write), 32'd0);
        chk("async_rst_depth", 32'(bus.depth), 32'd0);
        chk("async_rst_sp_address", 32'(bus.sp_address), 32'(SP_TOP));
        chk("async_rst_busy", 32'(bus.busy), 32'd0);
        bus.mem_busy = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, 1'b1, 16'h0000, 0, 1'b0);

        // Randomized mix of pushes, pops, simultaneous requests, stalls and clears
        for (int n = 0; n < 400; n++) begin
            int r;
            bit p;
            bit q;
            r = int'($urandom_range(0, 99));
            p = (r < 45) || (r >= 90);
            q = (r >= 45);
            issue(p, q, 16'($urandom), (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0),
                  ($urandom_range(0, 15) == 0));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("pending_writes", 32'(exp_wr.size()), 32'd0);
        chk("pending_pops", 32'(exp_pop.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
